// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode definitions: FSM state encoding, next-PC select
// codes (shared with dec) and the branch offset helper.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } fetch_state_t;

   localparam logic [1:0] SEL_SEQ    = 2'b00;
   localparam logic [1:0] SEL_BRANCH = 2'b01;
   localparam logic [1:0] SEL_JUMP   = 2'b10;
   localparam logic [1:0] SEL_JREG   = 2'b11;

   localparam logic [31:0] PC_STEP = 32'd4;

   // Word offset -> byte offset, sign-extended to 32 bits.
   function automatic logic [31:0] br_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// pc_next: combinational next-PC selection.
// Ports: i_pc, i_redirect, i_sel, i_br_taken, i_imm16, i_jtarget,
// i_rs_value in; o_pc_next out. All arithmetic wraps modulo 2^32.
module pc_next
   import fetch_unit_pkg::*;
(
   input  logic [31:0] i_pc,
   input  logic        i_redirect,
   input  logic [1:0]  i_sel,
   input  logic        i_br_taken,
   input  logic [15:0] i_imm16,
   input  logic [25:0] i_jtarget,
   input  logic [31:0] i_rs_value,
   output logic [31:0] o_pc_next
);

   logic [31:0] w_seq;
   logic [31:0] w_rs_aligned;

   assign w_seq        = i_pc + PC_STEP;
   assign w_rs_aligned = i_rs_value & 32'hFFFF_FFFC;

   always_comb begin
      o_pc_next = w_seq;
      if (i_redirect) begin
         case (i_sel)
            SEL_BRANCH: begin
               if (i_br_taken)
                  o_pc_next = w_seq + br_offset(i_imm16);
            end
            // Region bits come from PC+4, not PC.
            SEL_JUMP: o_pc_next = {w_seq[31:28], i_jtarget, 2'b00};
            SEL_JREG: o_pc_next = w_rs_aligned;
            default:  o_pc_next = w_seq;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IDLE/FETCH/HOLD instruction fetcher with one held slot.
// Ports: clk, rst; imem_addr/imem_req/imem_ack/imem_rdata to memory;
// instruction/inst_valid/inst_ready/pc_out to decode; redirect,
// PC_MUX_SEL, br_taken, imm16, jtarget, rs_value from decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] pc_out,
   input  logic        redirect,
   input  logic [1:0]  PC_MUX_SEL,
   input  logic        br_taken,
   input  logic [15:0] imm16,
   input  logic [25:0] jtarget,
   input  logic [31:0] rs_value
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic [31:0] r_pc_out;
   logic [31:0] w_pc_next;
   logic        w_req;
   logic        w_valid;
   logic        w_capture;
   logic        w_advance;

   pc_next u_pc_next (
      .i_pc       (r_pc),
      .i_redirect (redirect),
      .i_sel      (PC_MUX_SEL),
      .i_br_taken (br_taken),
      .i_imm16    (imm16),
      .i_jtarget  (jtarget),
      .i_rs_value (rs_value),
      .o_pc_next  (w_pc_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  w_state_nxt = ST_FETCH;
         ST_FETCH: if (imem_ack) w_state_nxt = ST_HOLD;
         ST_HOLD:  if (inst_ready) w_state_nxt = ST_FETCH;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_req     = 1'b0;
      w_valid   = 1'b0;
      w_capture = 1'b0;
      w_advance = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_req     = 1'b1;
            w_capture = imem_ack;
         end
         ST_HOLD: begin
            w_valid   = 1'b1;
            w_advance = inst_ready;
         end
         default: ;
      endcase
   end

   // Redirect operands only matter on the consuming HOLD cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_instr  <= 32'h0;
         r_pc_out <= 32'h0;
      end else begin
         if (w_capture) begin
            r_instr  <= imem_rdata;
            r_pc_out <= r_pc;
         end
         if (w_advance)
            r_pc <= w_pc_next;
      end
   end

   assign imem_addr   = r_pc;
   assign imem_req    = w_req;
   assign inst_valid  = w_valid;
   assign instruction = r_instr;
   assign pc_out      = r_pc_out;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: next-PC vector table plus
// hand-written reset, throughput, stall and reset-abort sequences.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] pc_out;
   logic        redirect;
   logic [1:0]  PC_MUX_SEL;
   logic        br_taken;
   logic [15:0] imm16;
   logic [25:0] jtarget;
   logic [31:0] rs_value;

   int n_chk;
   int n_err;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_req    (imem_req),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instruction (instruction),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .pc_out      (pc_out),
      .redirect    (redirect),
      .PC_MUX_SEL  (PC_MUX_SEL),
      .br_taken    (br_taken),
      .imm16       (imm16),
      .jtarget     (jtarget),
      .rs_value    (rs_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic [1:0]  sel;
      logic        bt;
      logic [15:0] imm;
      logic [25:0] jt;
      logic [31:0] rs;
      logic [31:0] pc;
      logic [31:0] exp;
   } vec_t;

   vec_t tv[10];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Drive garbage on decoder operands; fetch must ignore it.
   task automatic junk_ops();
      redirect   = 1'b1;
      PC_MUX_SEL = SEL_JREG;
      br_taken   = 1'b1;
      imm16      = 16'h8000;
      jtarget    = 26'h2AA_AAAA;
      rs_value   = 32'hDEAD_0000;
   endtask

   // From FETCH: one zero-wait fetch, then consume with given operands.
   task automatic go(input logic rd, input logic [1:0] sl,
                     input logic bt, input logic [15:0] im,
                     input logic [25:0] jt, input logic [31:0] rs,
                     input logic [31:0] dat);
      imem_ack   = 1'b1;
      imem_rdata = dat;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 32'hBAD0_BAD0;
      redirect   = rd;
      PC_MUX_SEL = sl;
      br_taken   = bt;
      imm16      = im;
      jtarget    = jt;
      rs_value   = rs;
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      junk_ops();
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;

      tv[0] = '{1'b1, SEL_BRANCH, 1'b1, 16'hFFFE, 26'h0, 32'h0,
                32'h0000_0100, 32'h0000_00FC};
      tv[1] = '{1'b1, SEL_BRANCH, 1'b0, 16'hFFFE, 26'h0, 32'h0,
                32'h0000_0100, 32'h0000_0104};
      tv[2] = '{1'b1, SEL_JUMP, 1'b0, 16'h0, 26'h9, 32'h0,
                32'h8000_0010, 32'h8000_0024};
      tv[3] = '{1'b1, SEL_JREG, 1'b0, 16'h0, 26'h0, 32'h0000_1237,
                32'h8000_0010, 32'h0000_1234};
      tv[4] = '{1'b0, SEL_JREG, 1'b1, 16'h0010, 26'h3FF_FFFF,
                32'hDEAD_BEEF, 32'h0000_0200, 32'h0000_0204};
      tv[5] = '{1'b1, SEL_SEQ, 1'b1, 16'h0010, 26'h0, 32'hDEAD_BEEF,
                32'h0000_0200, 32'h0000_0204};
      tv[6] = '{1'b0, SEL_SEQ, 1'b0, 16'h0, 26'h0, 32'h0,
                32'hFFFF_FFFC, 32'h0000_0000};
      tv[7] = '{1'b1, SEL_BRANCH, 1'b1, 16'h7FFF, 26'h0, 32'h0,
                32'h0000_1000, 32'h0002_1000};
      tv[8] = '{1'b1, SEL_JUMP, 1'b0, 16'h0, 26'h3FF_FFFF, 32'h0,
                32'hF000_0000, 32'hFFFF_FFFC};
      tv[9] = '{1'b1, SEL_JUMP, 1'b0, 16'h0, 26'h1, 32'h0,
                32'hFFFF_FFFC, 32'h0000_0004};

      // Reset, with ack/ready wiggling to prove nothing is captured.
      rst        = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      inst_ready = 1'b1;
      junk_ops();
      @(negedge clk);
      @(negedge clk);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_instr", instruction, 32'h0);
      chk("rst_pcout", pc_out, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);

      imem_ack   = 1'b0;
      inst_ready = 1'b0;
      rst        = 1'b0;
      #1;
      chk("idle_req", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      // Zero-wait streaming; redirect=0 must ignore the jump select.
      imem_ack   = 1'b1;
      inst_ready = 1'b1;
      redirect   = 1'b0;
      PC_MUX_SEL = SEL_JUMP;
      jtarget    = 26'h123_4567;
      for (int i = 0; i < 6; i++) begin
         imem_rdata = 32'hA000_0000 | imem_addr;
         if (i % 2 == 0) begin
            chk("strm_req", {31'b0, imem_req}, 32'd1);
            chk("strm_vld", {31'b0, inst_valid}, 32'd0);
            chk("strm_addr", imem_addr, 32'(4 * (i / 2)));
         end else begin
            chk("strm_req", {31'b0, imem_req}, 32'd0);
            chk("strm_vld", {31'b0, inst_valid}, 32'd1);
            chk("strm_pc", pc_out, 32'(4 * (i / 2)));
            chk("strm_ins", instruction,
                32'hA000_0000 | 32'(4 * (i / 2)));
         end
         @(negedge clk);
      end
      imem_ack   = 1'b0;
      inst_ready = 1'b0;
      junk_ops();
      chk("strm_next", imem_addr, 32'h0000_000C);

      // Next-PC table.
      for (int i = 0; i < 10; i++) begin
         go(1'b1, SEL_JREG, 1'b0, 16'h0, 26'h0, tv[i].pc,
            32'h1000_0000 + 32'(i));
         chk($sformatf("v%0d_setup", i), imem_addr, tv[i].pc);
         imem_ack   = 1'b1;
         imem_rdata = 32'h2000_0000 + 32'(i);
         @(negedge clk);
         imem_ack = 1'b0;
         chk($sformatf("v%0d_pcout", i), pc_out, tv[i].pc);
         chk($sformatf("v%0d_ins", i), instruction,
             32'h2000_0000 + 32'(i));
         redirect   = tv[i].rd;
         PC_MUX_SEL = tv[i].sel;
         br_taken   = tv[i].bt;
         imm16      = tv[i].imm;
         jtarget    = tv[i].jt;
         rs_value   = tv[i].rs;
         inst_ready = 1'b1;
         @(negedge clk);
         inst_ready = 1'b0;
         junk_ops();
         chk($sformatf("v%0d_next", i), imem_addr, tv[i].exp);
         chk($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'd1);
      end

      // Slow memory then stalled consumer.
      go(1'b1, SEL_JREG, 1'b0, 16'h0, 26'h0, 32'h0000_0300,
         32'h3333_3333);
      for (int i = 0; i < 3; i++) begin
         chk("wait_req", {31'b0, imem_req}, 32'd1);
         chk("wait_addr", imem_addr, 32'h0000_0300);
         chk("wait_vld", {31'b0, inst_valid}, 32'd0);
         @(negedge clk);
      end
      imem_ack   = 1'b1;
      imem_rdata = 32'h1234_5678;
      @(negedge clk);
      imem_rdata = 32'hBAD0_BAD0;
      for (int i = 0; i < 4; i++) begin
         chk("stall_vld", {31'b0, inst_valid}, 32'd1);
         chk("stall_req", {31'b0, imem_req}, 32'd0);
         chk("stall_ins", instruction, 32'h1234_5678);
         chk("stall_pc", pc_out, 32'h0000_0300);
         chk("stall_addr", imem_addr, 32'h0000_0300);
         @(negedge clk);
      end
      imem_ack   = 1'b0;
      redirect   = 1'b0;
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      chk("stall_next", imem_addr, 32'h0000_0304);
      chk("stall_vld0", {31'b0, inst_valid}, 32'd0);

      // Reset while holding an instruction.
      imem_ack   = 1'b1;
      imem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("hold_pre", {31'b0, inst_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("hrst_vld", {31'b0, inst_valid}, 32'd0);
      chk("hrst_ins", instruction, 32'h0);
      chk("hrst_pc", pc_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset mid-FETCH at PC=0x40, with ack present at the same time.
      go(1'b1, SEL_JREG, 1'b0, 16'h0, 26'h0, 32'h0000_0040,
         32'h7777_7777);
      chk("mf_addr", imem_addr, 32'h0000_0040);
      chk("mf_req", {31'b0, imem_req}, 32'd1);
      #2 rst = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 32'h9999_9999;
      #1;
      chk("mf_req0", {31'b0, imem_req}, 32'd0);
      chk("mf_vld0", {31'b0, inst_valid}, 32'd0);
      chk("mf_addr0", imem_addr, 32'h0);
      chk("mf_ins0", instruction, 32'h0);
      @(negedge clk);
      imem_ack = 1'b0;
      rst      = 1'b0;
      #1;
      chk("mf_idle", {31'b0, imem_req}, 32'd0);
      @(negedge clk);
      chk("mf_restart", {31'b0, imem_req}, 32'd1);
      chk("mf_raddr", imem_addr, 32'h0);
      chk("mf_noins", instruction, 32'h0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
